// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [7:0] DEFAULT_ID_BASE = 8'h30;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An unlimited packet length still needs a one-bit counter to keep widths legal.
  function automatic int cnt_width(input int max_pkt);
    return (max_pkt > 0) ? $clog2(max_pkt + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [NUM_SRC-1:0]         gnt,
  output logic [$clog2(NUM_SRC)-1:0] gnt_idx
);

  localparam int IDW = idx_width(NUM_SRC);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int off = NUM_SRC; off >= 1; off--) begin
      idx = (int'(ptr) + off) % NUM_SRC;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI-Stream byte channel among NUM_SRC sources,
// with optional per-packet ID header and a maximum-length guard.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int                     NUM_SRC     = 4,
  parameter int                     WORD_LENGTH = 8,
  parameter int                     INSERT_ID   = 1,
  parameter logic [WORD_LENGTH-1:0] ID_BASE     = WORD_LENGTH'(DEFAULT_ID_BASE),
  parameter int                     MAX_PKT     = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_SRC*WORD_LENGTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]             s_axis_valid,
  input  logic [NUM_SRC-1:0]             s_axis_last,
  output logic [NUM_SRC-1:0]             s_axis_ready,
  output logic [WORD_LENGTH-1:0]         m_axis_data,
  output logic                           m_axis_valid,
  output logic                           m_axis_last,
  input  logic                           m_axis_ready,
  output logic [$clog2(NUM_SRC)-1:0]     grant_id,
  output logic                           busy,
  output logic                           trunc_err
);

  localparam int             IDW      = idx_width(NUM_SRC);
  localparam int             CNTW     = cnt_width(MAX_PKT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((MAX_PKT > 0) ? MAX_PKT - 1 : 0);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  arb_state_t      state_reg;
  logic [IDW-1:0]  grant_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [CNTW-1:0] beat_cnt_reg;
  logic            trunc_err_reg;

  logic [NUM_SRC-1:0]     rr_gnt;
  logic [IDW-1:0]         rr_idx;
  logic [WORD_LENGTH-1:0] src_data [NUM_SRC];
  logic                   g_valid;
  logic                   g_last;
  logic [WORD_LENGTH-1:0] g_data;
  logic                   limit_hit;
  logic                   beat_accept;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr (
    .req     (s_axis_valid),
    .ptr     (ptr_reg),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Only the granted lane reaches the output; the ready fan-out is gated the same way.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_data[gi]     = s_axis_data[gi*WORD_LENGTH +: WORD_LENGTH];
    assign s_axis_ready[gi] = (state_reg == DATA) && (grant_reg == IDW'(gi)) && m_axis_ready;
  end

  assign g_valid     = s_axis_valid[grant_reg];
  assign g_last      = s_axis_last[grant_reg];
  assign g_data      = src_data[grant_reg];
  assign limit_hit   = (MAX_PKT != 0) && (beat_cnt_reg == CNT_LAST);
  assign beat_accept = (state_reg == DATA) && g_valid && m_axis_ready;

  always_comb begin
    m_axis_valid = 1'b0;
    m_axis_data  = '0;
    m_axis_last  = 1'b0;
    case (state_reg)
      HDR: begin
        m_axis_valid = 1'b1;
        m_axis_data  = ID_BASE + WORD_LENGTH'(grant_reg);
      end
      DATA: begin
        m_axis_valid = g_valid;
        m_axis_data  = g_data;
        m_axis_last  = g_last || limit_hit;
      end
      default: ;
    endcase
  end

  assign grant_id  = grant_reg;
  assign busy      = (state_reg != IDLE);
  assign trunc_err = trunc_err_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      ptr_reg       <= IDW'(NUM_SRC - 1);
      beat_cnt_reg  <= '0;
      trunc_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|rr_gnt) begin
            grant_reg    <= rr_idx;
            beat_cnt_reg <= '0;
            state_reg    <= (INSERT_ID != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (m_axis_ready) state_reg <= DATA;
        end
        DATA: begin
          if (beat_accept) begin
            if (beat_cnt_reg != CNT_MAX) beat_cnt_reg <= beat_cnt_reg + CNTW'(1);
            if (m_axis_last) begin
              state_reg <= IDLE;
              ptr_reg   <= grant_reg;
              // A forced last leaves the rest of the source's packet for a later grant.
              if (!g_last) trunc_err_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one DUT with ID header and MAX_PKT=4, one without header.
module tb_uart_tx_arbiter;

  localparam int NS = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NS*W-1:0] s_data;
  logic [NS-1:0]   s_valid, s_last;
  logic            m_ready;
  logic            sel;
  logic            rdy_mode;
  logic            rdy_val;

  logic [NS*W-1:0] in0_data, in1_data;
  logic [NS-1:0]   in0_valid, in1_valid, in0_last, in1_last;
  logic [NS-1:0]   r0, r1;
  logic [W-1:0]    md0, md1;
  logic            mv0, mv1, ml0, ml1;
  logic [1:0]      gid0, gid1;
  logic            busy0, busy1, te0, te1;

  assign in0_data  = sel ? '0 : s_data;
  assign in0_valid = sel ? '0 : s_valid;
  assign in0_last  = sel ? '0 : s_last;
  assign in1_data  = sel ? s_data  : '0;
  assign in1_valid = sel ? s_valid : '0;
  assign in1_last  = sel ? s_last  : '0;

  uart_tx_arbiter #(.NUM_SRC(NS), .WORD_LENGTH(W), .INSERT_ID(1), .ID_BASE(8'h30), .MAX_PKT(4)) dut0 (
    .clk(clk), .rstn(rstn), .s_axis_data(in0_data), .s_axis_valid(in0_valid), .s_axis_last(in0_last),
    .s_axis_ready(r0), .m_axis_data(md0), .m_axis_valid(mv0), .m_axis_last(ml0), .m_axis_ready(m_ready),
    .grant_id(gid0), .busy(busy0), .trunc_err(te0));

  uart_tx_arbiter #(.NUM_SRC(NS), .WORD_LENGTH(W), .INSERT_ID(0), .ID_BASE(8'h30), .MAX_PKT(64)) dut1 (
    .clk(clk), .rstn(rstn), .s_axis_data(in1_data), .s_axis_valid(in1_valid), .s_axis_last(in1_last),
    .s_axis_ready(r1), .m_axis_data(md1), .m_axis_valid(mv1), .m_axis_last(ml1), .m_axis_ready(m_ready),
    .grant_id(gid1), .busy(busy1), .trunc_err(te1));

  logic [NS-1:0] rdy;
  logic [W-1:0]  md;
  logic          mv, ml;
  assign rdy = sel ? r1  : r0;
  assign md  = sel ? md1 : md0;
  assign mv  = sel ? mv1 : mv0;
  assign ml  = sel ? ml1 : ml0;

  // Per-source beat queues, popped only on an accepted handshake.
  logic [8:0] smem [NS][32];
  int         hd [NS];
  int         tl [NS];
  logic [NS-1:0] acc;
  int         cyc;

  logic [W-1:0] out_d [64];
  logic         out_l [64];
  int           out_c [64];
  int           out_n;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic drive_src();
    for (int i = 0; i < NS; i++) begin
      if (hd[i] < tl[i]) begin
        s_valid[i]       = 1'b1;
        s_last[i]        = smem[i][hd[i]][8];
        s_data[i*W +: W] = smem[i][hd[i]][7:0];
      end else begin
        s_valid[i]       = 1'b0;
        s_last[i]        = 1'b0;
        s_data[i*W +: W] = 8'h00;
      end
    end
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic l);
    smem[src][tl[src]] = {l, d};
    tl[src] = tl[src] + 1;
    drive_src();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    acc = s_valid & rdy;
    if (rstn && mv && m_ready && out_n < 64) begin
      out_d[out_n] = md;
      out_l[out_n] = ml;
      out_c[out_n] = cyc;
      out_n = out_n + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    for (int i = 0; i < NS; i++)
      if (acc[i] && hd[i] < tl[i]) hd[i] = hd[i] + 1;
    m_ready = rdy_mode ? (cyc % 3 == 0) : rdy_val;
    drive_src();
  end

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < NS; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    rdy_mode = 1'b0;
    rdy_val  = 1'b0;
    drive_src();
    tick();
    tick();
    rstn  = 1'b1;
    out_n = 0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (r0 !== 4'b0)  begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", r0); end
    n_checks++; if (mv0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", mv0); end
    n_checks++; if (ml0 !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", ml0); end
    n_checks++; if (md0 !== 8'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00", md0); end
    n_checks++; if (gid0 !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", gid0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    n_checks++; if (te0 !== 1'b0) begin n_fail++; $display("FAIL reset_trunc: got %b expected 0", te0); end
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [8:0] exp_b [4];
    exp_b = '{9'h032, 9'h041, 9'h042, 9'h143};
    do_reset();
    rdy_val = 1'b1;
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b0);
    push(2, 8'h43, 1'b1);
    tick();
    n_checks++; if (!(mv0 === 1'b1 && md0 === 8'h32))
      begin n_fail++; $display("FAIL single_latency: got valid %b data %h expected valid 1 data 32", mv0, md0); end
    for (int c = 0; c < 20 && out_n < 4; c++) tick();
    n_checks++; if (out_n != 4) begin n_fail++; $display("FAIL single_count: got %0d expected 4", out_n); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({out_l[k], out_d[k]} !== exp_b[k])
        begin n_fail++; $display("FAIL single_beat%0d: got %h expected %h", k, {out_l[k], out_d[k]}, exp_b[k]); end
    end
    n_checks++; if (gid0 !== 2'd2) begin n_fail++; $display("FAIL single_grant: got %0d expected 2", gid0); end
    tick();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy0); end
    $display("test_single done: %0d beats", out_n);
  endtask

  task automatic test_multi();
    logic [8:0] exp_b [9];
    exp_b = '{9'h030, 9'h010, 9'h111, 9'h031, 9'h020, 9'h121, 9'h033, 9'h040, 9'h141};
    do_reset();
    rdy_val = 1'b1;
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    push(3, 8'h40, 1'b0); push(3, 8'h41, 1'b1);
    for (int c = 0; c < 60 && out_n < 9; c++) begin
      tick();
      n_checks++;
      if ((r0 & ~(4'b0001 << gid0)) !== 4'b0)
        begin n_fail++; $display("FAIL multi_other_ready: got %b with grant %0d expected only granted bit", r0, gid0); end
    end
    n_checks++; if (out_n != 9) begin n_fail++; $display("FAIL multi_count: got %0d expected 9", out_n); end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if ({out_l[k], out_d[k]} !== exp_b[k])
        begin n_fail++; $display("FAIL multi_beat%0d: got %h expected %h", k, {out_l[k], out_d[k]}, exp_b[k]); end
    end
    $display("test_multi done: %0d beats", out_n);
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_b [4];
    logic       in_data;
    exp_b   = '{9'h031, 9'h051, 9'h052, 9'h153};
    in_data = 1'b0;
    do_reset();
    rdy_mode = 1'b1;
    push(1, 8'h51, 1'b0);
    push(1, 8'h52, 1'b0);
    push(1, 8'h53, 1'b1);
    for (int c = 0; c < 60 && out_n < 4; c++) begin
      tick();
      n_checks++;
      if (r0 !== (in_data ? {2'b00, m_ready, 1'b0} : 4'b0000))
        begin n_fail++; $display("FAIL bp_ready_mirror: got %b expected %b", r0, in_data ? {2'b00, m_ready, 1'b0} : 4'b0000); end
      in_data = (out_n >= 1 && out_n < 4);
    end
    rdy_mode = 1'b0;
    rdy_val  = 1'b1;
    n_checks++; if (out_n != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", out_n); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({out_l[k], out_d[k]} !== exp_b[k])
        begin n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", k, {out_l[k], out_d[k]}, exp_b[k]); end
    end
    $display("test_backpressure done: %0d beats", out_n);
  endtask

  task automatic test_trunc();
    logic [8:0] exp_b [8];
    exp_b = '{9'h031, 9'h061, 9'h062, 9'h063, 9'h164, 9'h031, 9'h065, 9'h166};
    do_reset();
    n_checks++; if (te0 !== 1'b0) begin n_fail++; $display("FAIL trunc_before: got %b expected 0", te0); end
    rdy_val = 1'b1;
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b0);
    push(1, 8'h64, 1'b0); push(1, 8'h65, 1'b0); push(1, 8'h66, 1'b1);
    for (int c = 0; c < 40 && out_n < 8; c++) tick();
    n_checks++; if (out_n != 8) begin n_fail++; $display("FAIL trunc_count: got %0d expected 8", out_n); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({out_l[k], out_d[k]} !== exp_b[k])
        begin n_fail++; $display("FAIL trunc_beat%0d: got %h expected %h", k, {out_l[k], out_d[k]}, exp_b[k]); end
    end
    tick();
    n_checks++; if (te0 !== 1'b1) begin n_fail++; $display("FAIL trunc_flag: got %b expected 1", te0); end
    $display("test_trunc done: %0d beats", out_n);
  endtask

  // Runs straight after test_trunc so trunc_err is set and the pointer sits at source 1.
  task automatic test_reset_mid();
    logic found;
    found   = 1'b0;
    out_n   = 0;
    rdy_val = 1'b1;
    push(2, 8'h55, 1'b0); push(2, 8'h56, 1'b0); push(2, 8'h57, 1'b0); push(2, 8'h58, 1'b1);
    for (int c = 0; c < 10 && out_n < 1; c++) tick();
    rdy_val = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      found = (mv0 === 1'b1 && md0 === 8'h55);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_hold: got data %h expected 55 on output", md0); end
    rstn = 1'b0;
    #1;
    n_checks++; if (r0 !== 4'b0)  begin n_fail++; $display("FAIL rmid_ready: got %b expected 0000", r0); end
    n_checks++; if (mv0 !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", mv0); end
    n_checks++; if (md0 !== 8'h0) begin n_fail++; $display("FAIL rmid_data: got %h expected 00", md0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy0); end
    n_checks++; if (gid0 !== 2'd0) begin n_fail++; $display("FAIL rmid_grant: got %0d expected 0", gid0); end
    n_checks++; if (te0 !== 1'b0) begin n_fail++; $display("FAIL rmid_trunc: got %b expected 0", te0); end
    for (int i = 0; i < NS; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive_src();
    tick();
    rstn = 1'b1;
    push(2, 8'h70, 1'b1);
    push(0, 8'h71, 1'b1);
    tick();
    n_checks++; if (!(mv0 === 1'b1 && md0 === 8'h30 && gid0 === 2'd0))
      begin n_fail++; $display("FAIL rmid_rearb: got valid %b data %h grant %0d expected 1 30 0", mv0, md0, gid0); end
    $display("test_reset_mid done");
  endtask

  task automatic test_no_id();
    logic [8:0] exp_b [12];
    exp_b = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1};
    do_reset();
    sel     = 1'b1;
    rdy_val = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
      push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
    end
    for (int c = 0; c < 80 && out_n < 12; c++) tick();
    n_checks++; if (out_n != 12) begin n_fail++; $display("FAIL noid_count: got %0d expected 12", out_n); end
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if ({out_l[k], out_d[k]} !== exp_b[k])
        begin n_fail++; $display("FAIL noid_beat%0d: got %h expected %h", k, {out_l[k], out_d[k]}, exp_b[k]); end
    end
    for (int k = 1; k < 12; k++) begin
      n_checks++;
      if (out_c[k] - out_c[k-1] != (exp_b[k-1][8] ? 2 : 1))
        begin n_fail++; $display("FAIL noid_gap%0d: got %0d expected %0d", k, out_c[k] - out_c[k-1], exp_b[k-1][8] ? 2 : 1); end
    end
    sel = 1'b0;
    $display("test_no_id done: %0d beats", out_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel      = 1'b0;
    m_ready  = 1'b0;
    rdy_mode = 1'b0;
    rdy_val  = 1'b0;
    cyc      = 0;
    out_n    = 0;
    acc      = '0;
    for (int i = 0; i < NS; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive_src();
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_trunc();
    test_reset_mid();
    test_no_id();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
